// File: rtl/br_pred_update_pkg.sv
// br_pred_update_pkg: 2-bit saturating counter type, reset value and training function
package br_pred_update_pkg;
   typedef logic [1:0] lc3b_sat2;
   localparam lc3b_sat2 SAT2_WNT = 2'b01;
   function automatic lc3b_sat2 sat2_next(lc3b_sat2 c, logic up);
      return up ? ((c == 2'b11) ? c : c + 2'b01) : ((c == 2'b00) ? c : c - 2'b01);
   endfunction
endpackage

// File: rtl/br_pred_update_sat2_table.sv
// br_pred_update_sat2_table: 2**iw x 2-bit saturating counters, one async read port, one train port
//   clk, reset         clock, async active-high reset (all entries -> SAT2_WNT)
//   rd_index/rd_data   combinational lookup; a same-edge train is not forwarded
//   wr_en/wr_index/wr_up  train the addressed counter up (taken) or down
module br_pred_update_sat2_table
   import br_pred_update_pkg::*;
#(
   parameter int iw = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [iw-1:0] rd_index,
   output lc3b_sat2      rd_data,
   input  logic          wr_en,
   input  logic [iw-1:0] wr_index,
   input  logic          wr_up
);
   lc3b_sat2 mem [2**iw];
   assign rd_data = mem[rd_index];
   always_ff @(posedge clk or posedge reset)
      if (reset)
         for (int i = 0; i < 2**iw; i++) mem[i] <= SAT2_WNT;
      else if (wr_en)
         mem[wr_index] <= sat2_next(mem[wr_index], wr_up);
endmodule

// File: rtl/br_pred_update.sv
// br_pred_update: tournament branch predictor state, IF lookup and EX resolution
//   clk, reset            clock, async active-high reset
//   lk_local_index/lk_global_index  IF lookup indices
//   lk_pred, lk_taken     {local, global} counter MSBs and chooser-selected prediction
//   ghr                   non-speculative global history, newest outcome in bit 0
//   upd_*                 resolved branch from EX with the prediction fields carried down the pipe
//   mispredict            registered pulse the cycle after a wrongly predicted resolution
module br_pred_update
   import br_pred_update_pkg::*;
#(
   parameter int ls = 8,
   parameter int gs = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [ls-1:0] lk_local_index,
   input  logic [gs-1:0] lk_global_index,
   output logic [1:0]    lk_pred,
   output logic          lk_taken,
   output logic [gs-1:0] ghr,
   input  logic          upd_valid,
   input  logic          upd_actual_taken,
   input  logic          upd_pred_taken,
   input  logic [1:0]    upd_pred,
   input  logic [ls-1:0] upd_local_index,
   input  logic [gs-1:0] upd_global_index,
   output logic          mispredict
);
   lc3b_sat2 local_ctr, global_ctr, chooser_ctr;
   // chooser only learns when the two components disagreed; then exactly one was right
   logic ch_en, ch_up;
   assign ch_en = upd_valid & (upd_pred[1] ^ upd_pred[0]);
   assign ch_up = (upd_pred[0] == upd_actual_taken);
   br_pred_update_sat2_table #(.iw(ls)) u_local (
      .clk(clk), .reset(reset), .rd_index(lk_local_index), .rd_data(local_ctr),
      .wr_en(upd_valid), .wr_index(upd_local_index), .wr_up(upd_actual_taken));
   br_pred_update_sat2_table #(.iw(gs)) u_global (
      .clk(clk), .reset(reset), .rd_index(lk_global_index), .rd_data(global_ctr),
      .wr_en(upd_valid), .wr_index(upd_global_index), .wr_up(upd_actual_taken));
   br_pred_update_sat2_table #(.iw(gs)) u_chooser (
      .clk(clk), .reset(reset), .rd_index(lk_global_index), .rd_data(chooser_ctr),
      .wr_en(ch_en), .wr_index(upd_global_index), .wr_up(ch_up));
   assign lk_pred  = {local_ctr[1], global_ctr[1]};
   assign lk_taken = chooser_ctr[1] ? global_ctr[1] : local_ctr[1];
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         ghr        <= '0;
         mispredict <= 1'b0;
      end else begin
         if (upd_valid) ghr <= {ghr[gs-2:0], upd_actual_taken};
         mispredict <= upd_valid & (upd_pred_taken != upd_actual_taken);
      end
endmodule

// File: tb/tb_br_pred_update.sv
// tb_br_pred_update: directed and random checks of br_pred_update against an integer reference model
module tb_br_pred_update;
   logic       clk = 1'b0, reset = 1'b1;
   logic [7:0] lk_local_index = '0, upd_local_index = '0;
   logic [5:0] lk_global_index = '0, upd_global_index = '0, ghr;
   logic [1:0] lk_pred, upd_pred = '0;
   logic       lk_taken, upd_valid = 1'b0, upd_actual_taken = 1'b0, upd_pred_taken = 1'b0, mispredict;
   int tests = 0, fails = 0;
   int lp [256], gp [64], ch [64];
   int gh, mp;

   br_pred_update #(.ls(8), .gs(6)) dut (
      .clk(clk), .reset(reset), .lk_local_index(lk_local_index), .lk_global_index(lk_global_index),
      .lk_pred(lk_pred), .lk_taken(lk_taken), .ghr(ghr), .upd_valid(upd_valid),
      .upd_actual_taken(upd_actual_taken), .upd_pred_taken(upd_pred_taken), .upd_pred(upd_pred),
      .upd_local_index(upd_local_index), .upd_global_index(upd_global_index), .mispredict(mispredict));

   always #5 clk = ~clk;

   task automatic check(string tag, logic [31:0] o, logic [31:0] e);
      tests++;
      assert (o === e) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 256; i++) lp[i] = 1;
      for (int i = 0; i < 64; i++) begin gp[i] = 1; ch[i] = 1; end
      gh = 0; mp = 0;
   endtask

   function automatic int train(int c, bit up);
      return up ? ((c < 3) ? c + 1 : 3) : ((c > 0) ? c - 1 : 0);
   endfunction

   task automatic check_lk(string tag);
      bit lt, gt;
      lt = lp[lk_local_index] >= 2;
      gt = gp[lk_global_index] >= 2;
      check({tag, "_pred"}, lk_pred, {lt, gt});
      check({tag, "_taken"}, lk_taken, (ch[lk_global_index] >= 2) ? gt : lt);
   endtask

   // called at a negedge; returns at the following negedge with upd_valid low
   task automatic upd(int li, int gi, bit [1:0] pr, bit pt, bit act);
      upd_valid = 1'b1; upd_local_index = li[7:0]; upd_global_index = gi[5:0];
      upd_pred = pr; upd_pred_taken = pt; upd_actual_taken = act;
      lk_local_index = li[7:0]; lk_global_index = gi[5:0];
      #1 check_lk("same_cycle_old");
      @(posedge clk); #1;
      lp[li] = train(lp[li], act);
      gp[gi] = train(gp[gi], act);
      if (pr[1] != pr[0]) ch[gi] = train(ch[gi], pr[0] == act);
      gh = ((gh * 2) + int'(act)) % 64;
      mp = int'(pt != act);
      upd_valid = 1'b0;
      check_lk("after_update");
      check("ghr", ghr, gh);
      check("mispredict", mispredict, mp);
      @(negedge clk);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         check("idle_ghr", ghr, gh);
         check("idle_mispredict", mispredict, 0);
      end
      @(negedge clk);
   endtask

   initial begin
      model_reset();
      #2;
      check("reset_ghr", ghr, 0);
      check("reset_mispredict", mispredict, 0);
      check_lk("reset_lookup");
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      // history from reset
      upd(1, 1, 2'b00, 1'b0, 1'b1);
      upd(2, 2, 2'b00, 1'b0, 1'b0);
      upd(3, 3, 2'b00, 1'b0, 1'b1);
      upd(4, 4, 2'b00, 1'b0, 1'b1);
      check("ghr_1011", ghr, 6'b001011);
      idle(3);
      // saturation at local 05 / global 00
      upd(5, 0, 2'b00, 1'b0, 1'b1);
      check("sat_first_taken", lk_pred, 2'b11);
      upd(5, 0, 2'b11, 1'b1, 1'b1);
      upd(5, 0, 2'b11, 1'b1, 1'b1);
      upd(5, 0, 2'b11, 1'b1, 1'b1);
      upd(5, 0, 2'b11, 1'b1, 1'b0);
      upd(5, 0, 2'b11, 1'b1, 1'b0);
      check("sat_back_to_wnt", lk_pred, 2'b00);
      // chooser moves toward global when only global was right
      upd(8'h10, 6'h0A, 2'b01, 1'b0, 1'b1);
      lk_local_index = 8'h20; lk_global_index = 6'h0A;
      #1 check("chooser_follows_global", lk_taken, 1'b1);
      check_lk("chooser_lookup");
      @(negedge clk);
      // agreement leaves chooser alone; mispredict is a single pulse
      upd(8'h10, 6'h0A, 2'b11, 1'b1, 1'b0);
      check("hold_mispredict", mispredict, 1'b1);
      idle(1);
      lk_local_index = 8'h20; lk_global_index = 6'h0A;
      #1 check_lk("chooser_hold");
      @(negedge clk);
      // random traffic on a small index range so counters saturate and alias
      for (int n = 0; n < 300; n++) begin
         upd($urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom), 1'($urandom), 1'($urandom));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      // make mispredict high, then reset asynchronously between edges
      upd(0, 0, 2'b00, 1'b1, 1'b0);
      check("pre_reset_mispredict", mispredict, 1'b1);
      #2 reset = 1'b1;
      model_reset();
      #1;
      check("async_reset_ghr", ghr, 0);
      check("async_reset_mispredict", mispredict, 0);
      for (int i = 0; i < 256; i++) begin
         lk_local_index = i[7:0]; lk_global_index = i[5:0];
         #1;
         if (lk_pred !== 2'b00 || lk_taken !== 1'b0) check("async_reset_lookup", {lk_pred, lk_taken}, 0);
      end
      check_lk("async_reset_lookup_last");
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
      upd(7, 7, 2'b00, 1'b0, 1'b1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
